// File: rtl/dec_rr_arbiter.sv
// Four-requester round-robin arbiter with a bounded hold time.
// The winner is kept as a 2-bit index and expanded to a one-hot grant via a 2:4 decode.
module dec_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned IDX_W  = 2;
  localparam int unsigned REQ_N  = 4;
  localparam int unsigned HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic [IDX_W-1:0]   last_idx;
  logic [IDX_W-1:0]   last_nxt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_nxt;
  logic [REQ_N-1:0]   gnt_nxt;
  logic               valid_nxt;
  logic               timeout_nxt;

  logic               release_c;
  logic               expire_c;
  logic [IDX_W-1:0]   base_c;
  logic [IDX_W-1:0]   cand_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic               win_found_c;

  // Owner gives up the resource this edge, either voluntarily or by hold expiry.
  always_comb begin
    expire_c  = (state == GRANT) && req[gnt_idx] && (hold_cnt >= HOLD_LIMIT);
    release_c = (state == GRANT) && (!req[gnt_idx] || (hold_cnt >= HOLD_LIMIT));
    base_c    = release_c ? gnt_idx : last_idx;
  end

  // Scan base+1 .. base+4; walking downward lets the nearest set request win.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = base_c;
    cand_c      = base_c;
    for (int i = REQ_N; i >= 1; i--) begin
      cand_c = base_c + IDX_W'(i);
      if (req[cand_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
  end

  // State register together with the registered outputs and bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      hold_cnt  <= '0;
      last_idx  <= 2'b11;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt_idx   <= idx_nxt;
      hold_cnt  <= hold_nxt;
      last_idx  <= last_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = gnt_idx;
    hold_nxt  = hold_cnt;
    last_nxt  = last_idx;
    case (state)
      IDLE: begin
        if (win_found_c) begin
          state_nxt = GRANT;
          idx_nxt   = win_idx_c;
          hold_nxt  = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (release_c) begin
          last_nxt = gnt_idx;
          if (win_found_c) begin
            idx_nxt  = win_idx_c;
            hold_nxt = HOLD_W'(1);
          end else begin
            state_nxt = IDLE;
            hold_nxt  = '0;
          end
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: values loaded into the output registers on the next edge.
  always_comb begin
    valid_nxt   = (state_nxt == GRANT);
    timeout_nxt = expire_c;
    gnt_nxt     = '0;
    if (valid_nxt) begin
      case (idx_nxt)
        2'b00:   gnt_nxt = 4'b0001;
        2'b01:   gnt_nxt = 4'b0010;
        2'b10:   gnt_nxt = 4'b0100;
        default: gnt_nxt = 4'b1000;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Directed bench for dec_rr_arbiter: one DUT with MAX_HOLD=4, one with MAX_HOLD=2.
module tb_dec_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req4;
  logic [3:0] req2;
  logic [3:0] gnt4, gnt2;
  logic [1:0] idx4, idx2;
  logic       val4, val2;
  logic       to4, to2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dec_rr_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4),
    .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(val4), .timeout(to4)
  );

  dec_rr_arbiter #(.MAX_HOLD(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2),
    .gnt(gnt2), .gnt_idx(idx2), .gnt_valid(val2), .timeout(to2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req4 = 4'b0000;
    req2 = 4'b0000;
    tick();
    tick();
    checks++;
    if ({gnt4, idx4, val4, to4} !== 8'b0000_00_0_0) begin
      failures++;
      $display("FAIL reset_dut4: got %b expected %b", {gnt4, idx4, val4, to4}, 8'b0000_00_0_0);
    end
    checks++;
    if ({gnt2, idx2, val2, to2} !== 8'b0000_00_0_0) begin
      failures++;
      $display("FAIL reset_dut2: got %b expected %b", {gnt2, idx2, val2, to2}, 8'b0000_00_0_0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({gnt4, val4} !== 5'b0000_0) begin
      failures++;
      $display("FAIL idle_no_req: got %b expected %b", {gnt4, val4}, 5'b0000_0);
    end
  endtask

  task automatic test_single_request();
    req4 = 4'b0100;
    tick();
    checks++;
    if ({gnt4, idx4, val4, to4} !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL single_grant: got %b expected %b", {gnt4, idx4, val4, to4}, {4'b0100, 2'd2, 1'b1, 1'b0});
    end
    req4 = 4'b0000;
    tick();
    checks++;
    if ({gnt4, val4, to4} !== 6'b0000_0_0) begin
      failures++;
      $display("FAIL single_release: got %b expected %b", {gnt4, val4, to4}, 6'b0000_0_0);
    end
  endtask

  // last_idx=2 here, so from req=0011 requester 0 wins first.
  task automatic test_voluntary_release();
    req4 = 4'b0011;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if ({gnt4, idx4, val4, to4} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL vol_hold_%0d: got %b expected %b", k, {gnt4, idx4, val4, to4}, {4'b0001, 2'd0, 1'b1, 1'b0});
      end
    end
    req4 = 4'b0010;
    tick();
    checks++;
    if ({gnt4, idx4, val4, to4} !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL vol_handover: got %b expected %b", {gnt4, idx4, val4, to4}, {4'b0010, 2'd1, 1'b1, 1'b0});
    end
    req4 = 4'b0000;
    tick();
  endtask

  // MAX_HOLD=4 sole requester: re-granted in place, timeout after grant cycles 4 and 8.
  task automatic test_sole_expiry();
    logic exp_to;
    req4 = 4'b1000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_to = (k == 5) || (k == 9);
      checks++;
      if ({gnt4, idx4, val4, to4} !== {4'b1000, 2'd3, 1'b1, exp_to}) begin
        failures++;
        $display("FAIL sole_expiry_%0d: got %b expected %b", k, {gnt4, idx4, val4, to4}, {4'b1000, 2'd3, 1'b1, exp_to});
      end
    end
    req4 = 4'b0000;
    tick();
    checks++;
    if ({gnt4, val4, to4} !== 6'b0000_0_0) begin
      failures++;
      $display("FAIL sole_release: got %b expected %b", {gnt4, val4, to4}, 6'b0000_0_0);
    end
  endtask

  // last grant went to 3, so 0 must beat 3.
  task automatic test_wrap_priority();
    req4 = 4'b1001;
    tick();
    checks++;
    if ({gnt4, idx4, val4} !== {4'b0001, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL wrap_priority: got %b expected %b", {gnt4, idx4, val4}, {4'b0001, 2'd0, 1'b1});
    end
    req4 = 4'b0000;
    tick();
  endtask

  // last_idx=0: 1 wins, then 1 drops and 2 takes over with no bubble,
  // then 2 drops while 0 and 3 arrive on the same edge: 3 is next after 2.
  task automatic test_back_to_back();
    req4 = 4'b0110;
    tick();
    checks++;
    if ({gnt4, idx4, val4} !== {4'b0010, 2'd1, 1'b1}) begin
      failures++;
      $display("FAIL b2b_first: got %b expected %b", {gnt4, idx4, val4}, {4'b0010, 2'd1, 1'b1});
    end
    req4 = 4'b0100;
    tick();
    checks++;
    if ({gnt4, idx4, val4, to4} !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL b2b_handover: got %b expected %b", {gnt4, idx4, val4, to4}, {4'b0100, 2'd2, 1'b1, 1'b0});
    end
    req4 = 4'b1001;
    tick();
    checks++;
    if ({gnt4, idx4, val4, to4} !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL b2b_simul_new: got %b expected %b", {gnt4, idx4, val4, to4}, {4'b1000, 2'd3, 1'b1, 1'b0});
    end
    req4 = 4'b0000;
    tick();
  endtask

  // last_idx=3 here, so 1 wins from 0010; reset then restores priority to requester 0.
  task automatic test_reset_mid();
    req4 = 4'b0010;
    tick();
    checks++;
    if ({gnt4, val4} !== {4'b0010, 1'b1}) begin
      failures++;
      $display("FAIL mid_pre: got %b expected %b", {gnt4, val4}, {4'b0010, 1'b1});
    end
    rst  = 1'b1;
    req4 = 4'b1111;
    tick();
    checks++;
    if ({gnt4, idx4, val4, to4} !== 8'b0000_00_0_0) begin
      failures++;
      $display("FAIL mid_reset: got %b expected %b", {gnt4, idx4, val4, to4}, 8'b0000_00_0_0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({gnt4, idx4, val4, to4} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mid_after: got %b expected %b", {gnt4, idx4, val4, to4}, {4'b0001, 2'd0, 1'b1, 1'b0});
    end
    req4 = 4'b0000;
    tick();
  endtask

  // MAX_HOLD=2 with all four requesting: 0,0,1,1,2,2,3,3,0,0.
  task automatic test_fairness();
    logic [3:0] exp_gnt [10];
    logic       exp_to  [10];
    exp_gnt = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
    exp_to  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    req2 = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({gnt2, val2, to2} !== {exp_gnt[k], 1'b1, exp_to[k]}) begin
        failures++;
        $display("FAIL fair_%0d: got %b expected %b", k, {gnt2, val2, to2}, {exp_gnt[k], 1'b1, exp_to[k]});
      end
    end
    req2 = 4'b0000;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_request();
    test_voluntary_release();
    test_sole_expiry();
    test_wrap_priority();
    test_back_to_back();
    test_reset_mid();
    test_fairness();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec_rr_arbiter.md
# dec_rr_arbiter

Four-requester round-robin arbiter built around the shared 2-to-4 decoder. It sequences ownership of a single shared resource among requesters 0–3. It holds the winning requester as a 2-bit index and expands that index to a one-hot grant through a 2:4 decode. It enforces a maximum hold time so that no requester can starve the others.

## Interface
Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held (legal range 1–255)

Ports (clock and reset first):
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- req  input  4  request vector; bit n high means requester n wants the resource
- gnt  output  4  one-hot grant; the 2:4 decode of gnt_idx, gated by gnt_valid
- gnt_idx  output  2  index of the current owner; meaningful only when gnt_valid=1
- gnt_valid  output  1  a grant is active
- timeout  output  1  one-cycle pulse on the edge where a grant is revoked by MAX_HOLD expiry

## Operation
- Reset is synchronous and active-high.
  - All outputs are registered.
  - While rst=1 at a rising edge, and in the cycle after it: state=IDLE, gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, timeout=0, hold_cnt=0, last_idx=2'b11.
  - With last_idx=3 after reset, requester 0 has top priority first.
- State machine has two states: IDLE and GRANT.
  - IDLE, req==0: stay in IDLE.
  - IDLE, req!=0: pick a winner, go to GRANT, set gnt_idx=winner, set hold_cnt=1.
  - GRANT, req[gnt_idx]=1 and hold_cnt<MAX_HOLD: stay in GRANT and increment hold_cnt.
  - GRANT, req[gnt_idx]=0 (voluntary release): set last_idx=gnt_idx, then re-arbitrate on the same edge.
    - Winner found: stay in GRANT with the new gnt_idx and hold_cnt=1.
    - No winner: go to IDLE.
  - GRANT, req[gnt_idx]=1 and hold_cnt==MAX_HOLD (expiry): set last_idx=gnt_idx, pulse timeout=1, then re-arbitrate as above.
    - The expiring requester is eligible again but has the lowest priority.
    - If it is the only requester, it is re-granted with hold_cnt=1 and gnt_valid stays high.
- Winner selection: scan last_idx+1, +2, +3, +4 (mod 4) and take the first set req bit.
  - Index arithmetic is 2-bit and wraps 3→0.
- Grant generation: gnt = gnt_valid ? decode(gnt_idx) : 0.
  - The decode is the standard 2:4: 00→0001, 01→0010, 10→0100, 11→1000.
  - gnt is never multi-hot.
- hold_cnt is 8 bits wide and never exceeds MAX_HOLD.
- Requests that change while not granted have no effect until the next arbitration edge.

## Timing
- Latency from req rising (IDLE) to gnt: 1 clock. req is sampled at edge N; gnt is valid after edge N.
- Back-to-back handover has no bubble.
  - On a release edge with other requests pending, gnt switches directly from the old one-hot to the new one.
  - gnt_valid stays 1 throughout.
- Maximum continuous ownership is exactly MAX_HOLD cycles of gnt high.
- timeout is high for exactly the one cycle following the expiry edge.
- Release latency: req[gnt_idx] dropping at edge N clears that grant after edge N.
- Reset mid-grant: the next edge forces IDLE and outputs zero. It also restores last_idx=3, so priority is not preserved across reset.
- Simultaneous release and new request on the same edge: the new request is considered in that edge's arbitration.

## Test plan
- Reset then single request: rst for 2 cycles, then req=4'b0100 → gnt=4'b0100, gnt_idx=2, gnt_valid=1 one cycle after req is sampled; timeout=0.
- Round-robin fairness: req=4'b1111 held, MAX_HOLD=2 → grant sequence 0,0,1,1,2,2,3,3,0,… Gnt changes every 2 cycles with no zero cycle, and timeout pulses at each change.
- Voluntary release: req=4'b0011; requester 0 drops after 3 cycles of grant → gnt moves to 4'b0010 on that edge; timeout stays 0.
- Sole requester expiry: MAX_HOLD=4, req=4'b1000 held for 10 cycles → gnt=4'b1000 continuously and gnt_valid never drops. timeout pulses after grant cycles 4 and 8.
- Wrap-around priority: last grant to 3, then req=4'b1001 → next grant goes to 0, not 3.
- Reset mid-operation: with gnt=4'b0010 active, assert rst for 1 cycle with req=4'b1111 → outputs are zero the next cycle. After rst falls, requester 0 is granted first.
